// File: rtl/apb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_arbiter                                                  |
// | Description : Two-master round-robin APB requester with ACCESS timeout.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module apb_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic                  m0_req,
   input  logic                  m1_req,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   input  logic                  m0_write,
   input  logic                  m1_write,
   input  logic [3:0]            m0_stb,
   input  logic [3:0]            m1_stb,
   output logic                  m0_done,
   output logic                  m1_done,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  m0_err,
   output logic                  m1_err,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pdata,
   output logic                  pwrite,
   output logic [3:0]            pstb,
   output logic                  psel,
   output logic                  penable,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready,
   input  logic                  perr
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   localparam int unsigned    CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W:0] C_TMO = (CNT_W + 1)'(TIMEOUT);

   logic [1:0]            state_q, state_d;
   logic                  grant_q, grant_d;
   logic                  last_grant_q, last_grant_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
   logic                  pwrite_q, pwrite_d;
   logic [3:0]            pstb_q, pstb_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  done0_q, done0_d, done1_q, done1_d;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic                  err0_q, err0_d, err1_q, err1_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic [CNT_W:0]        w_cnt_inc;
   logic                  w_tmo_hit;
   logic                  w_finish;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic                  w_err;

   assign w_cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
   // Timeout fires on the ACCESS cycle that would bring the count to TIMEOUT
   assign w_tmo_hit = (TIMEOUT != 0) && (w_cnt_inc >= C_TMO);

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      paddr_d      = paddr_q;
      pdata_d      = pdata_q;
      pwrite_d     = pwrite_q;
      pstb_d       = pstb_q;
      psel_d       = psel_q;
      penable_d    = penable_q;
      done0_d      = 1'b0;
      done1_d      = 1'b0;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      err0_d       = err0_q;
      err1_d       = err1_q;
      cnt_d        = cnt_q;
      w_finish     = 1'b0;
      w_rdata      = '0;
      w_err        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (m0_req || m1_req) begin
               grant_d  = m1_req & (~m0_req | ~last_grant_q);
               paddr_d  = grant_d ? m1_addr  : m0_addr;
               pdata_d  = grant_d ? m1_wdata : m0_wdata;
               pwrite_d = grant_d ? m1_write : m0_write;
               pstb_d   = grant_d ? m1_stb   : m0_stb;
               psel_d   = 1'b1;
               cnt_d    = '0;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
            state_d   = ST_ACCESS;
         end
         ST_ACCESS: begin
            // A real completion always beats a coincident timeout
            if (pready || perr) begin
               w_finish = 1'b1;
               w_err    = perr;
               w_rdata  = (perr || pwrite_q) ? '0 : prdata;
            end else if (w_tmo_hit) begin
               w_finish = 1'b1;
               w_err    = 1'b1;
            end else if (!(&cnt_q)) begin
               cnt_d = w_cnt_inc[CNT_W-1:0];
            end
            if (w_finish) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               state_d   = ST_RESP;
               if (grant_q) begin
                  done1_d  = 1'b1;
                  rdata1_d = w_rdata;
                  err1_d   = w_err;
               end else begin
                  done0_d  = 1'b1;
                  rdata0_d = w_rdata;
                  err0_d   = w_err;
               end
            end
         end
         ST_RESP: begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q      <= ST_IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         paddr_q      <= '0;
         pdata_q      <= '0;
         pwrite_q     <= 1'b0;
         pstb_q       <= '0;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         done0_q      <= 1'b0;
         done1_q      <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         err0_q       <= 1'b0;
         err1_q       <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         paddr_q      <= paddr_d;
         pdata_q      <= pdata_d;
         pwrite_q     <= pwrite_d;
         pstb_q       <= pstb_d;
         psel_q       <= psel_d;
         penable_q    <= penable_d;
         done0_q      <= done0_d;
         done1_q      <= done1_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         err0_q       <= err0_d;
         err1_q       <= err1_d;
         cnt_q        <= cnt_d;
      end
   end

   assign paddr    = paddr_q;
   assign pdata    = pdata_q;
   assign pwrite   = pwrite_q;
   assign pstb     = pstb_q;
   assign psel     = psel_q;
   assign penable  = penable_q;
   assign m0_done  = done0_q;
   assign m1_done  = done1_q;
   assign m0_rdata = rdata0_q;
   assign m1_rdata = rdata1_q;
   assign m0_err   = err0_q;
   assign m1_err   = err1_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_apb_arbiter                                               |
// | Description : Directed self-checking bench for apb_arbiter (TIMEOUT=4).    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_apb_arbiter;

   logic        pclk = 1'b0;
   logic        presetn;
   logic        m0_req, m1_req;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic        m0_write, m1_write;
   logic [3:0]  m0_stb, m1_stb;
   logic        m0_done, m1_done;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_err, m1_err;
   logic [31:0] paddr, pdata;
   logic        pwrite;
   logic [3:0]  pstb;
   logic        psel, penable;
   logic [31:0] prdata;
   logic        pready, perr;

   int checks = 0;
   int errors = 0;

   apb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
      .pclk(pclk), .presetn(presetn),
      .m0_req(m0_req), .m1_req(m1_req),
      .m0_addr(m0_addr), .m1_addr(m1_addr),
      .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
      .m0_write(m0_write), .m1_write(m1_write),
      .m0_stb(m0_stb), .m1_stb(m1_stb),
      .m0_done(m0_done), .m1_done(m1_done),
      .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
      .m0_err(m0_err), .m1_err(m1_err),
      .paddr(paddr), .pdata(pdata), .pwrite(pwrite), .pstb(pstb),
      .psel(psel), .penable(penable),
      .prdata(prdata), .pready(pready), .perr(perr)
   );

   always #5 pclk = ~pclk;

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      presetn = 1'b0;
      m0_req = 0; m1_req = 0; m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
      m0_write = 0; m1_write = 0; m0_stb = 0; m1_stb = 0;
      prdata = 0; pready = 0; perr = 0;
      step(); step();
      chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_pstb", pstb, 0);
      chk("rst_done", {m0_done, m1_done}, 0);
      chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
      chk("rst_err", {m0_err, m1_err}, 0);
      presetn = 1'b1;
      step();

      // Single read by m0
      m0_req = 1; m0_addr = 32'h8000_0010; m0_write = 0; m0_stb = 4'hF;
      step();
      chk("rd_setup_psel", {psel, penable}, 2'b10);
      chk("rd_setup_paddr", paddr, 32'h8000_0010);
      chk("rd_setup_pwrite", pwrite, 0);
      pready = 1; prdata = 32'hDEAD_BEEF;
      step();
      chk("rd_access", {psel, penable}, 2'b11);
      chk("rd_access_nodone", m0_done, 0);
      step();
      chk("rd_resp_done", {m0_done, m1_done}, 2'b10);
      chk("rd_resp_rdata", m0_rdata, 32'hDEAD_BEEF);
      chk("rd_resp_err", m0_err, 0);
      chk("rd_resp_psel", {psel, penable}, 2'b00);
      m0_req = 0; pready = 0;
      step();
      chk("rd_idle_done", m0_done, 0);
      chk("rd_idle_hold", m0_rdata, 32'hDEAD_BEEF);

      // m1 write, pready delayed three ACCESS cycles (completion coincides with timeout)
      m1_req = 1; m1_addr = 32'h0100_0000; m1_wdata = 32'h41; m1_write = 1; m1_stb = 4'h1;
      prdata = 32'h1234_5678;
      step();
      chk("wr_setup_fields", {paddr, pdata, 3'b0, pwrite, pstb}, {32'h0100_0000, 32'h41, 4'h1, 4'h1});
      step();
      for (int i = 0; i < 4; i++) begin
         chk("wr_access", {psel, penable, m1_done}, 3'b110);
         chk("wr_fields_stable", {paddr, pdata, 3'b0, pwrite, pstb}, {32'h0100_0000, 32'h41, 4'h1, 4'h1});
         if (i == 3) pready = 1;
         step();
      end
      chk("wr_resp_done", {m0_done, m1_done}, 2'b01);
      chk("wr_resp_err", m1_err, 0);
      chk("wr_resp_rdata", m1_rdata, 0);
      chk("wr_m0_hold", m0_rdata, 32'hDEAD_BEEF);
      m1_req = 0; pready = 0;
      step();
      chk("wr_done_once", m1_done, 0);
      chk("wr_pwrite_hold", pwrite, 1);

      // Both masters continuously requesting from reset: m0, m1, m0, m1
      presetn = 0;
      step();
      presetn = 1;
      step();
      m0_req = 1; m0_addr = 32'h100; m0_write = 0;
      m1_req = 1; m1_addr = 32'h200; m1_write = 0;
      pready = 1;
      for (int k = 0; k < 4; k++) begin
         prdata = 32'hA0 + k;
         step();
         chk("rr_grant_addr", paddr, (k % 2) ? 32'h200 : 32'h100);
         step();
         step();
         chk("rr_done", {m0_done, m1_done}, (k % 2) ? 2'b01 : 2'b10);
         chk("rr_rdata", (k % 2) ? m1_rdata : m0_rdata, 32'hA0 + k);
         step();
      end
      m0_req = 0; m1_req = 0; pready = 0;
      step();

      // Decoder fault: perr without pready
      m0_req = 1; m0_addr = 32'h500; m0_write = 0; perr = 1; prdata = 32'hBAD;
      step();
      step();
      chk("flt_access", {psel, penable}, 2'b11);
      step();
      chk("flt_done", {m0_done, m1_done}, 2'b10);
      chk("flt_err", m0_err, 1);
      chk("flt_rdata", m0_rdata, 0);
      m0_req = 0; perr = 0;
      step();
      chk("flt_err_hold", m0_err, 1);

      // Timeout: exactly four ACCESS cycles
      m1_req = 1; m1_addr = 32'h2000; m1_write = 0; prdata = 32'hCAFE;
      step();
      step();
      for (int i = 0; i < 4; i++) begin
         chk("tmo_access", {psel, penable, m1_done}, 3'b110);
         step();
      end
      chk("tmo_done", {m0_done, m1_done}, 2'b01);
      chk("tmo_err", m1_err, 1);
      chk("tmo_rdata", m1_rdata, 0);
      chk("tmo_psel", {psel, penable}, 2'b00);
      m1_req = 0;
      step();

      // Follow-up read with three wait states must not time out early
      m1_req = 1; m1_addr = 32'h2004; prdata = 32'h55;
      step();
      step();
      for (int i = 0; i < 4; i++) begin
         chk("post_tmo_access", {penable, m1_done}, 2'b10);
         if (i == 3) pready = 1;
         step();
      end
      chk("post_tmo_done", m1_done, 1);
      chk("post_tmo_err", m1_err, 0);
      chk("post_tmo_rdata", m1_rdata, 32'h55);
      m1_req = 0; pready = 0;
      step();

      // Reset asserted mid-ACCESS
      m0_req = 1; m0_addr = 32'h300;
      step();
      step();
      chk("rst_mid_access", {psel, penable}, 2'b11);
      #2 presetn = 0;
      #1;
      chk("rst_mid_async", {psel, penable}, 2'b00);
      chk("rst_mid_paddr", paddr, 0);
      chk("rst_mid_status", {m0_err, m1_err, m0_rdata, m1_rdata}, 0);
      step();
      chk("rst_mid_nodone", {m0_done, m1_done}, 2'b00);
      presetn = 1;
      m1_req = 1; m1_addr = 32'h400; pready = 1; prdata = 32'h77;
      step();
      chk("rst_tie_grant", paddr, 32'h300);
      step();
      step();
      chk("rst_tie_done", {m0_done, m1_done}, 2'b10);
      chk("rst_tie_rdata", m0_rdata, 32'h77);
      m0_req = 0; m1_req = 0; pready = 0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/apb_arbiter.md
# apb_arbiter

Two-master APB requester/arbiter. It sits between the core's instruction-fetch port (m0) and load/store port (m1) on one side and the shared APB bus feeding the address decoder (SRAM, UART, system) on the other. It round-robin arbitrates requests and sequences APB SETUP/ACCESS phases. It returns registered read data and error status per master, and terminates stalled or faulted transfers via perr or a timeout counter.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- TIMEOUT, 255, max ACCESS-phase cycles before forced error; 0 disables timeout

Ports:
- pclk  in  1  bus clock; all state on rising edge
- presetn  in  1  asynchronous, active-low reset
- m0_req, m1_req  in  1  transfer request; held with fields stable until matching done
- m0_addr, m1_addr  in  ADDR_WIDTH  transfer address
- m0_wdata, m1_wdata  in  DATA_WIDTH  write data
- m0_write, m1_write  in  1  1 = write, 0 = read
- m0_stb, m1_stb  in  4  byte strobes
- m0_done, m1_done  out  1  one-cycle completion pulse
- m0_rdata, m1_rdata  out  DATA_WIDTH  read data, valid with done, held until next done for that master
- m0_err, m1_err  out  1  error flag, valid with done, held like rdata
- paddr  out  ADDR_WIDTH  APB address
- pdata  out  DATA_WIDTH  APB write data
- pwrite  out  1  APB direction
- pstb  out  4  APB strobes
- psel  out  1  APB select
- penable  out  1  APB enable
- prdata  in  DATA_WIDTH  APB read data
- pready  in  1  APB ready
- perr  in  1  APB error (includes decoder access fault, which never raises pready)

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: if any req, pick grant, latch that master's addr/wdata/write/stb into paddr/pdata/pwrite/pstb, go SETUP; else stay.
- Arbitration: single req wins. When both request, grant the master not granted last (last_grant register).
- SETUP: psel=1, penable=0; unconditionally go ACCESS next cycle.
- ACCESS: psel=1, penable=1. Completion when pready=1 or perr=1. On completion, capture rdata=prdata (forced 0 for writes and on error), err=perr, go RESP.
- Timeout: counter clears on SETUP entry and increments each ACCESS cycle without completion. If it reaches TIMEOUT (TIMEOUT≠0) before completion, go RESP with err=1, rdata=0.
- RESP: psel=penable=0; pulse done of the granted master, update last_grant; go IDLE.
- Request deasserted mid-transfer is ignored; the transfer completes and done still pulses.
- Counter width is clog2(TIMEOUT+1), minimum 1; it saturates and never wraps.
- pwrite/paddr/pdata/pstb hold their last values outside transfers.

## Timing
- Reset (async, presetn=0): state IDLE; psel, penable, pwrite, paddr, pdata, pstb, m*_done, m*_rdata, m*_err all 0; last_grant=1, so m0 wins the first tie; counter 0.
- All outputs are registered; no combinational path from any input to any output.
- req sampled high in IDLE at cycle N: SETUP at N+1, ACCESS at N+2. pready at N+2 gives RESP/done at N+3 and IDLE at N+4. Minimum 4 cycles per transfer.
- Each pready-low ACCESS cycle adds one cycle of latency.
- The master may keep req high through the RESP cycle. req high in the following IDLE cycle is a new transfer.
- pready and perr high in the same cycle: complete with err=1, rdata=0.
- Completion and timeout in the same cycle: completion wins (err=perr).
- Reset asserted mid-transfer: psel/penable drop immediately and no done is issued.

## Test plan
- Single read, m0 addr 0x80000010, pready=1 at first ACCESS, prdata=0xDEADBEEF: psel at N+1, penable at N+2, m0_done at N+3, m0_rdata=0xDEADBEEF, m0_err=0.
- m1 write 0x1000000 data 0x41 stb 0x1, pready delayed 3 cycles: APB fields stable throughout, penable held 4 cycles, m1_done once, m1_err=0, m1_rdata=0.
- Both req from reset with continuous requests: grants m0, m1, m0, m1. Each done pulse appears only on the granted master.
- Unmapped address 0x500, perr=1 with pready=0: transfer ends on the first ACCESS cycle, err=1, rdata=0.
- TIMEOUT=4, pready/perr held 0: exactly 4 ACCESS cycles, then RESP with err=1. Next request proceeds normally.
- presetn pulsed low during ACCESS: all outputs 0 asynchronously, no done; after release, a new request completes correctly and m0 wins a tie.
